mux4_way16_reg: RTL and testbench

Four-input, 16-bit-wide selector with a registered output. Each cycle it picks one of four data words (`a`, `b`, `c`, `d`) using a 2-bit select and presents the chosen word on `out` after the next rising clock edge. It is a datapath primitive in the CPU-to-FPGA build, used where ALU operands and register-file read ports are steered and a clean, glitch-free registered result is needed.

---
 rtl/mux_pkg.sv | 13 +
 rtl/mux2way16.sv | 16 +
 rtl/mux4_way16_reg.sv | 54 +++++
 tb/tb_mux4_way16_reg.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 16-bit word selectors: default width and select codes.
package mux_pkg;

  localparam int WIDTH = 16;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux2way16.sv
// Combinational 2:1 word mux; sel=0 picks a, sel=1 picks b.
module mux2way16
  import mux_pkg::*;
#(
  parameter int WIDTH = mux_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // AND-OR form so an unknown select propagates instead of quietly choosing a side.
  assign out = ({WIDTH{sel}} & b) | ({WIDTH{~sel}} & a);

endmodule

// File: rtl/mux4_way16_reg.sv
// Four-way word selector built as a two-level mux tree with a registered output.
module mux4_way16_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = mux_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] ab_sel;
  logic [WIDTH-1:0] cd_sel;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // sel[0] resolves each pair, sel[1] picks between the pairs.
  mux2way16 #(.WIDTH(WIDTH)) u_mux_ab (
    .a   (a),
    .b   (b),
    .sel (sel[0]),
    .out (ab_sel)
  );

  mux2way16 #(.WIDTH(WIDTH)) u_mux_cd (
    .a   (c),
    .b   (d),
    .sel (sel[0]),
    .out (cd_sel)
  );

  mux2way16 #(.WIDTH(WIDTH)) u_mux_final (
    .a   (ab_sel),
    .b   (cd_sel),
    .sel (sel[1]),
    .out (out_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mux4_way16_reg.sv
// Scoreboard bench for mux4_way16_reg: stimulus pushes expected words, a monitor pops and compares.
module tb_mux4_way16_reg;
  import mux_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b, c, d;
  sel_t        sel;
  logic [15:0] out;

  logic [15:0] exp_q[$];
  int          n_cmp;
  int          n_bad;
  bit          mon_en;

  mux4_way16_reg #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .sel   (sel),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the select code is simply an index into the list of four words.
  function automatic logic [15:0] model(input logic [15:0] wa, input logic [15:0] wb,
                                        input logic [15:0] wc, input logic [15:0] wd,
                                        input int s);
    logic [15:0] words [4];
    words[0] = wa;
    words[1] = wb;
    words[2] = wc;
    words[3] = wd;
    return words[s];
  endfunction

  task automatic drive_now(input logic [15:0] na, input logic [15:0] nb,
                           input logic [15:0] nc, input logic [15:0] nd, input int ns);
    a   = na;
    b   = nb;
    c   = nc;
    d   = nd;
    sel = sel_t'(ns);
    if (rst_n) exp_q.push_back(model(na, nb, nc, nd, ns));
  endtask

  task automatic drive(input logic [15:0] na, input logic [15:0] nb,
                       input logic [15:0] nc, input logic [15:0] nd, input int ns);
    @(negedge clk);
    drive_now(na, nb, nc, nd, ns);
  endtask

  // Monitor: the register presents a new word just after every rising edge out of reset.
  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got %h, wanted no output at %0t", out, $time);
      end else begin
        check("scoreboard", out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    mon_en = 1'b1;
    rst_n  = 1'b0;
    a = 16'hAAAA; b = 16'h5555; c = 16'hF0F0; d = 16'h0F0F;
    sel = SEL_D;

    // Reset held: output stays zero across edges.
    #3;
    check("reset_initial", out, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_after_edges", out, 16'h0000);

    // Release synchronously; first edge loads d.
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(16'hAAAA, 16'h5555, 16'hF0F0, 16'h0F0F, 3);

    // Select sweep.
    for (int s = 0; s < 4; s++) drive(16'hAAAA, 16'h5555, 16'hF0F0, 16'h0F0F, s);

    // Toggling sel between edges has no effect on the held output.
    drive(16'hAAAA, 16'h5555, 16'hF0F0, 16'h0F0F, 1);
    @(posedge clk);
    #2;
    sel = SEL_A;
    #1;
    check("hold_sel_toggle_a", out, 16'h5555);
    sel = SEL_C;
    #1;
    check("hold_sel_toggle_c", out, 16'h5555);

    // Data change on the selected and an unselected input.
    drive(16'hAAAA, 16'h5555, 16'h1234, 16'h0F0F, 2);
    drive(16'hFFFF, 16'h5555, 16'h1234, 16'h0F0F, 2);
    drive(16'hAAAA, 16'h5555, 16'hF0F0, 16'h0F0F, 2);

    // Asynchronous reset mid-cycle clears immediately.
    drive(16'hAAAA, 16'h5555, 16'hF0F0, 16'h0F0F, 1);
    @(posedge clk);
    #3;
    check("pre_async_reset", out, 16'h5555);
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", out, 16'h0000);
    @(posedge clk);
    #1;
    check("async_reset_held_edge", out, 16'h0000);

    // Random traffic.
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 16'(($urandom)),
              int'($urandom_range(3, 0)));
    for (int i = 0; i < 1000; i++)
      drive(16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 16'(($urandom)),
            int'($urandom_range(3, 0)));

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, wanted 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
